// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the ROM/SRAM port arbiter: FSM state codes,
// grant encoding, chip-enable / memory-op levels and wait-counter width.
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'b00,
        ARB_ACCESS = 2'b01,
        ARB_DONE   = 2'b10
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } arb_grant_t;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic ROM_OP_WRITE = 1'b1;
    localparam logic ROM_OP_READ  = 1'b0;

    localparam int WAIT_CNT_W = 3;

endpackage

// File: rtl/rom_port_arbiter_wait_counter.sv
// Loadable 3-bit down-counter used to time the ACCESS phase; zero marks the
// final memory cycle of an access.
module arb_wait_counter
    import rom_port_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic                  zero
);

    logic [WAIT_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbitrates the single ROM/SRAM port between instruction fetch and MEM-stage
// accesses (MEM has priority). Optional macro: ARB_POSTED_WRITE_EN (early write ack).
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [3:0]        mem_sel_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              stallreq_o,
    output logic              ram_ce_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [3:0]        ram_sel_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic [1:0]        dbg_state
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    arb_state_t state;
    arb_grant_t grant;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;
`ifdef ARB_POSTED_WRITE_EN
    logic       posted;
`endif

    // Counter is armed on every grant so ACCESS lasts exactly WAIT_CYCLES+1 cycles.
    assign cnt_load = (state == ARB_IDLE) && (mem_req_i || if_req_i);
    assign cnt_dec  = (state == ARB_ACCESS) && !cnt_zero;

    arb_wait_counter u_wait_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    assign stallreq_o = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            grant       <= GRANT_IF;
            if_ack_o    <= 1'b0;
            if_data_o   <= '0;
            mem_ack_o   <= 1'b0;
            mem_rdata_o <= '0;
            ram_ce_o    <= CHIP_DISABLE;
            ram_we_o    <= ROM_OP_READ;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            ram_sel_o   <= '0;
`ifdef ARB_POSTED_WRITE_EN
            posted      <= 1'b0;
`endif
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (mem_req_i) begin
                        grant       <= GRANT_MEM;
                        ram_addr_o  <= mem_addr_i;
                        ram_wdata_o <= mem_wdata_i;
                        ram_sel_o   <= mem_sel_i;
                        ram_we_o    <= mem_we_i ? ROM_OP_WRITE : ROM_OP_READ;
                        ram_ce_o    <= CHIP_ENABLE;
                        state       <= ARB_ACCESS;
`ifdef ARB_POSTED_WRITE_EN
                        // Posted write: requester is released now, the access runs on alone.
                        if (mem_we_i) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= '0;
                            posted      <= 1'b1;
                        end
`endif
                    end else if (if_req_i) begin
                        grant       <= GRANT_IF;
                        ram_addr_o  <= if_addr_i;
                        ram_wdata_o <= '0;
                        ram_sel_o   <= 4'b1111;
                        ram_we_o    <= ROM_OP_READ;
                        ram_ce_o    <= CHIP_ENABLE;
                        state       <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (cnt_zero) begin
                        ram_ce_o <= CHIP_DISABLE;
                        ram_we_o <= ROM_OP_READ;
`ifdef ARB_POSTED_WRITE_EN
                        if (posted) begin
                            posted <= 1'b0;
                            state  <= ARB_IDLE;
                        end else begin
                            state <= ARB_DONE;
                            if (grant == GRANT_MEM) begin
                                mem_ack_o   <= 1'b1;
                                mem_rdata_o <= ram_we_o ? '0 : ram_rdata_i;
                            end else begin
                                if_ack_o  <= 1'b1;
                                if_data_o <= ram_rdata_i;
                            end
                        end
`else
                        state <= ARB_DONE;
                        if (grant == GRANT_MEM) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= ram_we_o ? '0 : ram_rdata_i;
                        end else begin
                            if_ack_o  <= 1'b1;
                            if_data_o <= ram_rdata_i;
                        end
`endif
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state    <= ARB_IDLE;
                    ram_ce_o <= CHIP_DISABLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: cycle-exact scenario tasks plus a
// scoreboard of expected read data popped on every ack.
module tb_rom_port_arbiter;

`ifdef ARB_POSTED_WRITE_EN
    localparam int WR_ACK = 1;
`else
    localparam int WR_ACK = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];
    logic [31:0] if0_exp_q[$];

    // DUT with WAIT_CYCLES=1
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_sel = '0;
    logic [31:0] if_data, mem_rdata, ram_addr, ram_wdata, ram_rdata;
    logic        if_ack, mem_ack, stallreq, ram_ce, ram_we;
    logic [3:0]  ram_sel;
    logic [1:0]  dbg_state;

    // DUT with WAIT_CYCLES=0 (fetch-only traffic)
    logic        if0_req = 1'b0;
    logic [31:0] if0_addr = '0;
    logic        mem0_req = 1'b0, mem0_we = 1'b0;
    logic [31:0] mem0_addr = '0, mem0_wdata = '0;
    logic [3:0]  mem0_sel = '0;
    logic [31:0] if0_data, mem0_rdata, ram0_addr, ram0_wdata, ram0_rdata;
    logic        if0_ack, mem0_ack, stall0, ram0_ce, ram0_we;
    logic [3:0]  ram0_sel;
    logic [1:0]  dbg0_state;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0004: return 32'h2402_0001;
            32'h8000_0100: return 32'hDEAD_BEEF;
            default:       return a ^ 32'hA5A5_5A5A;
        endcase
    endfunction

    assign ram_rdata  = mem_model(ram_addr);
    assign ram0_rdata = mem_model(ram0_addr);

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ack_o(if_ack),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .mem_sel_i(mem_sel), .mem_rdata_o(mem_rdata),
        .mem_ack_o(mem_ack), .stallreq_o(stallreq), .ram_ce_o(ram_ce), .ram_we_o(ram_we),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata), .ram_sel_o(ram_sel),
        .ram_rdata_i(ram_rdata), .dbg_state(dbg_state)
    );

    rom_port_arbiter #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req_i(if0_req), .if_addr_i(if0_addr), .if_data_o(if0_data), .if_ack_o(if0_ack),
        .mem_req_i(mem0_req), .mem_we_i(mem0_we), .mem_addr_i(mem0_addr),
        .mem_wdata_i(mem0_wdata), .mem_sel_i(mem0_sel), .mem_rdata_o(mem0_rdata),
        .mem_ack_o(mem0_ack), .stallreq_o(stall0), .ram_ce_o(ram0_ce), .ram_we_o(ram0_we),
        .ram_addr_o(ram0_addr), .ram_wdata_o(ram0_wdata), .ram_sel_o(ram0_sel),
        .ram_rdata_i(ram0_rdata), .dbg_state(dbg0_state)
    );

    // Scoreboard: every ack pops the oldest expected value for that side.
    always @(negedge clk) begin
        if (!rst) begin
            if (if_ack) begin
                checks++;
                if (if_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL if_sb: unexpected if_ack, data %h, queue empty", if_data);
                end else if (if_data !== if_exp_q[0]) begin
                    errors++;
                    $display("FAIL if_sb: if_data %h expected %h", if_data, if_exp_q[0]);
                end
                if (if_exp_q.size() != 0) void'(if_exp_q.pop_front());
            end
            if (mem_ack) begin
                checks++;
                if (mem_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mem_sb: unexpected mem_ack, data %h, queue empty", mem_rdata);
                end else if (mem_rdata !== mem_exp_q[0]) begin
                    errors++;
                    $display("FAIL mem_sb: mem_rdata %h expected %h", mem_rdata, mem_exp_q[0]);
                end
                if (mem_exp_q.size() != 0) void'(mem_exp_q.pop_front());
            end
            if (if0_ack) begin
                checks++;
                if (if0_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL if0_sb: unexpected if_ack, data %h, queue empty", if0_data);
                end else if (if0_data !== if0_exp_q[0]) begin
                    errors++;
                    $display("FAIL if0_sb: if_data %h expected %h", if0_data, if0_exp_q[0]);
                end
                if (if0_exp_q.size() != 0) void'(if0_exp_q.pop_front());
            end
        end
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ram_ce, ram_we, if_ack, mem_ack, stallreq} !== 5'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_hold: ce/we/acks/stall %b state %0d expected 0", {ram_ce, ram_we, if_ack, mem_ack, stallreq}, dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(1);
        checks++;
        if ({if_data, mem_rdata, ram_addr, ram_wdata} !== 128'b0 || ram_sel !== 4'b0) begin
            errors++;
            $display("FAIL reset_data: data/addr outputs not zero (if %h mem %h addr %h)", if_data, mem_rdata, ram_addr);
        end
        checks++;
        if (ram0_ce !== 1'b0 || dbg0_state !== 2'd0 || if0_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut0: ce %b state %0d ack %b expected 0", ram0_ce, dbg0_state, if0_ack);
        end
    endtask

    task automatic test_reset_mid_access();
        if_req = 1'b1; if_addr = 32'h0000_0010;
        @(posedge clk); #1;
        checks++;
        if (ram_ce !== 1'b1 || dbg_state !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_pre: ce %b state %0d expected 1/1", ram_ce, dbg_state);
        end
        rst = 1'b1; if_req = 1'b0;
        #1;
        checks++;
        if (ram_ce !== 1'b0 || dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_mid_abort: ce %b state %0d expected 0/0", ram_ce, dbg_state);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (if_ack !== 1'b0 || dbg_state !== 2'd0 || ram_ce !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_after c%0d: ack %b state %0d ce %b expected 0", c, if_ack, dbg_state, ram_ce);
            end
        end
        idle_cycles(1);
    endtask

    task automatic test_if_read();
        if_req = 1'b1; if_addr = 32'h0000_0004;
        if_exp_q.push_back(32'h2402_0001);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (ram_ce !== (c == 1 || c == 2) || if_ack !== (c == 3) || stallreq !== (c <= 2)) begin
                errors++;
                $display("FAIL if_read c%0d: ce %b ack %b stall %b", c, ram_ce, if_ack, stallreq);
            end
            if (c == 1) begin
                checks++;
                if (ram_addr !== 32'h0000_0004 || ram_we !== 1'b0) begin
                    errors++;
                    $display("FAIL if_read_addr: addr %h we %b expected 00000004/0", ram_addr, ram_we);
                end
            end
            @(posedge clk); #1;
            if (c == 3) if_req = 1'b0;
        end
    endtask

    task automatic test_contention();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0100; mem_sel = 4'hF;
        if_req = 1'b1;  if_addr = 32'h0000_0008;
        mem_exp_q.push_back(32'hDEAD_BEEF);
        if_exp_q.push_back(mem_model(32'h0000_0008));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (mem_ack !== (c == 3) || if_ack !== (c == 7) || stallreq !== (c <= 6)) begin
                errors++;
                $display("FAIL contention c%0d: mem_ack %b if_ack %b stall %b", c, mem_ack, if_ack, stallreq);
            end
            if (c == 1 || c == 5) begin
                checks++;
                if (ram_addr !== ((c == 1) ? 32'h8000_0100 : 32'h0000_0008)) begin
                    errors++;
                    $display("FAIL contention_grant c%0d: ram_addr %h", c, ram_addr);
                end
            end
            @(posedge clk); #1;
            if (c == 3) mem_req = 1'b0;
            if (c == 7) if_req = 1'b0;
        end
    endtask

    task automatic test_write();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h8000_0008;
        mem_wdata = 32'h1234_5678; mem_sel = 4'b0011;
        mem_exp_q.push_back(32'h0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (mem_ack !== (c == WR_ACK) || ram_ce !== (c == 1 || c == 2) || ram_we !== (c == 1 || c == 2)) begin
                errors++;
                $display("FAIL write c%0d: ack %b ce %b we %b (ack due c%0d)", c, mem_ack, ram_ce, ram_we, WR_ACK);
            end
            if (c == 1 || c == 2) begin
                checks++;
                if (ram_sel !== 4'b0011 || ram_addr !== 32'h8000_0008 || ram_wdata !== 32'h1234_5678) begin
                    errors++;
                    $display("FAIL write_bus c%0d: sel %b addr %h wdata %h", c, ram_sel, ram_addr, ram_wdata);
                end
            end
            @(posedge clk); #1;
            if (c == WR_ACK) begin
                mem_req = 1'b0; mem_we = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        if0_req = 1'b1; if0_addr = 32'h0;
        if0_exp_q.push_back(mem_model(32'h0));
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            checks++;
            if (if0_ack !== (c == 2 || c == 5) || ram0_ce !== (c == 1 || c == 4)) begin
                errors++;
                $display("FAIL back_to_back c%0d: ack %b ce %b", c, if0_ack, ram0_ce);
            end
            @(posedge clk); #1;
            if (c == 2) begin
                if0_addr = 32'h4;
                if0_exp_q.push_back(mem_model(32'h4));
            end
            if (c == 5) if0_req = 1'b0;
        end
    endtask

    task automatic test_drop();
        logic [31:0] a;
        a = 32'h20 + 32'($urandom_range(0, 15) * 4);
        if_req = 1'b1; if_addr = a;
        if_exp_q.push_back(mem_model(a));
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            checks++;
            if (if_ack !== (c == 3) || mem_ack !== (c == 7)) begin
                errors++;
                $display("FAIL drop c%0d: if_ack %b mem_ack %b", c, if_ack, mem_ack);
            end
            if (c == 2) begin
                checks++;
                if (stallreq !== 1'b0) begin
                    errors++;
                    $display("FAIL drop_stall: stall %b expected 0", stallreq);
                end
            end
            @(posedge clk); #1;
            if (c == 0) if_req = 1'b0;
            if (c == 3) begin
                mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h8000_0100;
                mem_exp_q.push_back(32'hDEAD_BEEF);
            end
            if (c == 7) mem_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_access();
        test_if_read();
        idle_cycles(2);
        test_contention();
        idle_cycles(2);
        test_write();
        idle_cycles(2);
        test_back_to_back();
        idle_cycles(2);
        test_drop();
        idle_cycles(3);
        checks++;
        if (if_exp_q.size() != 0 || mem_exp_q.size() != 0 || if0_exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: pending if %0d mem %0d if0 %0d expected 0", if_exp_q.size(), mem_exp_q.size(), if0_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
